pwm_gate_gen: RTL and testbench
===============================

Name: pwm_gate_gen

Overview:
Consumer end of the PWM carrier path. Compares the IEEE-754 single-precision triangle carrier from the carrier generator against a floating-point modulating reference once per simulation step. Produces complementary switch gate signals with dead-time insertion, counted in simulation steps, for the PV converter switch models. Raises done_sig when the gates for that step are valid.

Parameters:
DEAD_STEPS, 2, number of simulation steps both gates are held low on each commutation (0 = direct commutation, max 255)
CNT_W, 16, width of the switching-event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sta  in  1  one-cycle step strobe; samples triangle_in, ref_in, gate_ena
triangle_in  in  32  carrier, IEEE-754 single
ref_in  in  32  modulating reference, IEEE-754 single
gate_ena  in  1  converter enable; 0 forces both gates low
cmp_raw  out  1  registered compare result (ref_in > triangle_in)
gate_hi  out  1  upper switch gate
gate_lo  out  1  lower switch gate
sw_count  out  CNT_W  number of entries into state HI, wraps modulo 2^CNT_W
done_sig  out  1  one-cycle pulse: gates valid for this step

Behaviour:
- Reset (synchronous, rst=1 at clock edge): all pipeline registers, cmp_raw, gate_hi, gate_lo, sw_count, done_sig = 0; FSM = OFF; dead counter = 0.
- Pipeline, fully pipelined, back-to-back sta accepted:
  - Edge k+1 after sta in cycle k: operands and gate_ena registered, v1=1.
  - Edge k+2: cmp_raw updated, v2=1.
  - Edge k+3: FSM and gates updated; done_sig=1 for exactly one cycle.
  - Latency sta->done_sig = 3 clocks.
  - Gates, FSM, and counters change only on v2 events.
- Float compare (combinational between stages 1 and 2), cmp = ref > tri:
  - Both operands zero (+0/-0 in any mix) -> 0.
  - Signs differ -> cmp = ~ref[31].
  - Both positive -> unsigned ref[30:0] > tri[30:0].
  - Both negative -> unsigned ref[30:0] < tri[30:0].
  - Equal -> 0. NaN/Inf are not produced upstream; no special handling.
- FSM states: OFF, DT (dead time, with target bit tgt and 8-bit cnt), HI (gate_hi=1), LO (gate_lo=1). Gates are decoded registered from the next state, so gate_hi and gate_lo are never both 1.
- FSM transitions, evaluated on each v2 event:
  - Any state, gate_ena_r=0 -> OFF, cnt=0. Disable wins over all other events.
  - OFF, ena=1 -> if DEAD_STEPS=0, go to HI/LO per cmp; else DT with tgt=cmp, cnt=1.
  - HI, cmp=0 (or LO, cmp=1) -> if DEAD_STEPS=0, go directly to the opposite state; else DT with tgt=cmp, cnt=1.
  - HI, cmp=1 / LO, cmp=0 -> hold.
  - DT, cmp!=tgt -> tgt=cmp, cnt=1 (dead time restarts).
  - DT, cmp==tgt and cnt==DEAD_STEPS -> HI if tgt=1 else LO.
  - DT otherwise -> cnt=cnt+1.
  - Net effect: both gates are low for exactly DEAD_STEPS steps after the last compare change.
- sw_count: +1 on every transition into HI, from any state, wraps to 0 at max.
- sta asserted in the same cycle as rst: ignored; no done_sig.
- Reset mid-operation flushes v1/v2; no done_sig for in-flight steps.

Test Plan:
1. Compare: ref=0x3F000000 (0.5), tri=0x3E800000 (0.25) -> cmp_raw=1 two clocks after sta. ref=0x00000000, tri=0x80000000 -> 0. ref=0xBF000000 (-0.5), tri=0xBE800000 (-0.25) -> 0. ref=0xBE800000, tri=0xBF000000 -> 1.
2. Enable with DEAD_STEPS=2, cmp=1 steady, gate_ena=1 from step 0 -> gate_hi=0 on steps 0-1, gate_hi=1 from step 2, gate_lo=0 throughout, sw_count=1. done_sig is exactly 3 clocks after each sta.
3. Commutation with DEAD_STEPS=2: in HI, cmp goes to 0 at step n -> both gates low on steps n and n+1, gate_lo=1 at step n+2. Each step's gate_hi & gate_lo = 0.
4. Glitch during dead time: HI, cmp sequence 0,1,1,1 -> DT restarts at the second step; back to HI after 2 steps at cmp=1; sw_count increments by 1.
5. Disable and reset: gate_ena=0 in the same step as a cmp change -> OFF, both gates 0. rst pulsed with two steps in flight -> no done_sig follows; all outputs 0.
6. DEAD_STEPS=0 variant: cmp alternating every step -> gates toggle directly each step with no low gap. Run 65537 HI entries -> sw_count wraps to 1.

Source files
------------

// File: rtl/pwm_gate_gen.sv
// Float carrier/reference compare driving complementary gates with dead-time insertion.
// Latency: sta -> done_sig is 3 clocks; fully pipelined, one step per clock accepted.
// Backpressure: none; every sta is processed and the consumer must take done_sig as it comes.
module pwm_gate_gen #(
    parameter int unsigned DEAD_STEPS = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sta,
    input  logic [31:0]      triangle_in,
    input  logic [31:0]      ref_in,
    input  logic             gate_ena,
    output logic             cmp_raw,
    output logic             gate_hi,
    output logic             gate_lo,
    output logic [CNT_W-1:0] sw_count,
    output logic             done_sig
);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_DT  = 2'd1,
        S_HI  = 2'd2,
        S_LO  = 2'd3
    } state_t;

    localparam logic [7:0] DEAD_CNT = 8'(DEAD_STEPS);

    // stage 1: sampled operands
    logic [31:0] tri_q, tri_d;
    logic [31:0] ref_q, ref_d;
    logic        ena1_q, ena1_d;
    logic        v1_q, v1_d;
    // stage 2: compare result
    logic        cmp_q, cmp_d;
    logic        ena2_q, ena2_d;
    logic        v2_q, v2_d;
    // stage 3: gate state machine
    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hi_q, hi_d;
    logic        lo_q, lo_d;
    logic [CNT_W-1:0] sw_q, sw_d;
    logic        done_q, done_d;

    logic        cmp_w;
    logic        both_zero;

    // Sign-magnitude compare ref > tri plus the first two pipeline stages
    always_comb begin
        both_zero = (tri_q[30:0] == 31'd0) && (ref_q[30:0] == 31'd0);
        if (both_zero) begin
            cmp_w = 1'b0;
        end else if (ref_q[31] != tri_q[31]) begin
            cmp_w = ~ref_q[31];
        end else if (!ref_q[31]) begin
            cmp_w = ref_q[30:0] > tri_q[30:0];
        end else begin
            cmp_w = ref_q[30:0] < tri_q[30:0];
        end

        tri_d  = tri_q;
        ref_d  = ref_q;
        ena1_d = ena1_q;
        v1_d   = sta;
        if (sta) begin
            tri_d  = triangle_in;
            ref_d  = ref_in;
            ena1_d = gate_ena;
        end

        cmp_d  = cmp_q;
        ena2_d = ena2_q;
        v2_d   = v1_q;
        if (v1_q) begin
            cmp_d  = cmp_w;
            ena2_d = ena1_q;
        end
    end

    // Gate FSM next state; only a completed compare (v2) moves it
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (v2_q) begin
            if (!ena2_q) begin
                state_d = S_OFF;
                cnt_d   = 8'd0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        if (DEAD_STEPS == 0) begin
                            state_d = cmp_q ? S_HI : S_LO;
                        end else begin
                            state_d = S_DT;
                            tgt_d   = cmp_q;
                            cnt_d   = 8'd1;
                        end
                    end
                    S_HI, S_LO: begin
                        if (cmp_q != (state_q == S_HI)) begin
                            if (DEAD_STEPS == 0) begin
                                state_d = cmp_q ? S_HI : S_LO;
                            end else begin
                                state_d = S_DT;
                                tgt_d   = cmp_q;
                                cnt_d   = 8'd1;
                            end
                        end
                    end
                    default: begin
                        if (cmp_q != tgt_q) begin
                            tgt_d = cmp_q;
                            cnt_d = 8'd1;
                        end else if (cnt_q == DEAD_CNT) begin
                            state_d = tgt_q ? S_HI : S_LO;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                endcase
            end
        end

        // gates follow the next state so they can never overlap
        hi_d   = (state_d == S_HI);
        lo_d   = (state_d == S_LO);
        sw_d   = sw_q;
        if (v2_q && (state_d == S_HI) && (state_q != S_HI)) begin
            sw_d = sw_q + 1'b1;
        end
        done_d = v2_q;
    end

    // All state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q   <= 32'd0;
            ref_q   <= 32'd0;
            ena1_q  <= 1'b0;
            v1_q    <= 1'b0;
            cmp_q   <= 1'b0;
            ena2_q  <= 1'b0;
            v2_q    <= 1'b0;
            state_q <= S_OFF;
            tgt_q   <= 1'b0;
            cnt_q   <= 8'd0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            sw_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            tri_q   <= tri_d;
            ref_q   <= ref_d;
            ena1_q  <= ena1_d;
            v1_q    <= v1_d;
            cmp_q   <= cmp_d;
            ena2_q  <= ena2_d;
            v2_q    <= v2_d;
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sw_q    <= sw_d;
            done_q  <= done_d;
        end
    end

    assign cmp_raw  = cmp_q;
    assign gate_hi  = hi_q;
    assign gate_lo  = lo_q;
    assign sw_count = sw_q;
    assign done_sig = done_q;

endmodule

// File: tb/tb_pwm_gate_gen.sv
module tb_pwm_gate_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        sta;
    logic [31:0] triangle_in;
    logic [31:0] ref_in;
    logic        gate_ena;

    logic        cmp_a, hi_a, lo_a, done_a;
    logic [15:0] sw_a;
    logic        cmp_b, hi_b, lo_b, done_b;
    logic [3:0]  sw_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] P50 = 32'h3F000000;
    localparam logic [31:0] P25 = 32'h3E800000;

    always #5 clk = ~clk;

    pwm_gate_gen #(.DEAD_STEPS(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .sta(sta), .triangle_in(triangle_in), .ref_in(ref_in),
        .gate_ena(gate_ena), .cmp_raw(cmp_a), .gate_hi(hi_a), .gate_lo(lo_a),
        .sw_count(sw_a), .done_sig(done_a)
    );

    pwm_gate_gen #(.DEAD_STEPS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .sta(sta), .triangle_in(triangle_in), .ref_in(ref_in),
        .gate_ena(gate_ena), .cmp_raw(cmp_b), .gate_hi(hi_b), .gate_lo(lo_b),
        .sw_count(sw_b), .done_sig(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one step at a negedge; returns at the negedge where its gates are valid.
    task automatic do_step(input logic [31:0] r, input logic [31:0] t, input logic e);
        sta = 1'b1; ref_in = r; triangle_in = t; gate_ena = e;
        @(negedge clk);
        sta = 1'b0;
        chk("done_a_lat1", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        chk("done_a_lat2", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        chk("done_a_lat3", {31'd0, done_a}, 32'd1);
        chk("done_b_lat3", {31'd0, done_b}, 32'd1);
        chk("excl_a", {31'd0, hi_a & lo_a}, 32'd0);
    endtask

    task automatic gates_a(input string tag, input logic h, input logic l, input int sw);
        chk({tag, "_hi"}, {31'd0, hi_a}, {31'd0, h});
        chk({tag, "_lo"}, {31'd0, lo_a}, {31'd0, l});
        chk({tag, "_sw"}, {16'd0, sw_a}, sw);
    endtask

    logic [31:0] vec_r [6];
    logic [31:0] vec_t [6];
    logic        vec_c [6];

    initial begin
        rst = 1'b1; sta = 1'b0; triangle_in = '0; ref_in = '0; gate_ena = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmp", {31'd0, cmp_a}, 32'd0);
        chk("rst_hi", {31'd0, hi_a}, 32'd0);
        chk("rst_lo", {31'd0, lo_a}, 32'd0);
        chk("rst_sw", {16'd0, sw_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);

        // back-to-back compare vectors, FSM held off
        vec_r[0] = P50;          vec_t[0] = P25;          vec_c[0] = 1'b1;
        vec_r[1] = 32'h00000000; vec_t[1] = 32'h80000000; vec_c[1] = 1'b0;
        vec_r[2] = 32'hBF000000; vec_t[2] = 32'hBE800000; vec_c[2] = 1'b0;
        vec_r[3] = 32'hBE800000; vec_t[3] = 32'hBF000000; vec_c[3] = 1'b1;
        vec_r[4] = P25;          vec_t[4] = 32'hBF000000; vec_c[4] = 1'b1;
        vec_r[5] = P25;          vec_t[5] = P25;          vec_c[5] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && i < 8) chk($sformatf("cmp_vec%0d", i - 2), {31'd0, cmp_a}, {31'd0, vec_c[i-2]});
            chk($sformatf("b2b_done%0d", i), {31'd0, done_a}, {31'd0, (i >= 3 && i <= 8)});
            if (i < 6) begin
                sta = 1'b1; ref_in = vec_r[i]; triangle_in = vec_t[i]; gate_ena = 1'b0;
            end else begin
                sta = 1'b0;
            end
            @(negedge clk);
        end
        gates_a("b2b_off", 1'b0, 1'b0, 0);

        // enable with steady cmp=1: two dead steps then HI
        do_step(P50, P25, 1'b1); gates_a("en_s0", 1'b0, 1'b0, 0);
        do_step(P50, P25, 1'b1); gates_a("en_s1", 1'b0, 1'b0, 0);
        do_step(P50, P25, 1'b1); gates_a("en_s2", 1'b1, 1'b0, 1);
        do_step(P50, P25, 1'b1); gates_a("en_s3", 1'b1, 1'b0, 1);

        // commutation HI -> LO
        do_step(P25, P50, 1'b1); gates_a("com_n0", 1'b0, 1'b0, 1);
        do_step(P25, P50, 1'b1); gates_a("com_n1", 1'b0, 1'b0, 1);
        do_step(P25, P50, 1'b1); gates_a("com_n2", 1'b0, 1'b1, 1);

        // back to HI, then glitch in dead time
        do_step(P50, P25, 1'b1); gates_a("ret_0", 1'b0, 1'b0, 1);
        do_step(P50, P25, 1'b1); gates_a("ret_1", 1'b0, 1'b0, 1);
        do_step(P50, P25, 1'b1); gates_a("ret_2", 1'b1, 1'b0, 2);
        do_step(P25, P50, 1'b1); gates_a("gl_0", 1'b0, 1'b0, 2);
        do_step(P50, P25, 1'b1); gates_a("gl_1", 1'b0, 1'b0, 2);
        do_step(P50, P25, 1'b1); gates_a("gl_2", 1'b0, 1'b0, 2);
        do_step(P50, P25, 1'b1); gates_a("gl_3", 1'b1, 1'b0, 3);

        // disable coinciding with a compare change
        do_step(P25, P50, 1'b0); gates_a("dis", 1'b0, 1'b0, 3);

        // reset with two steps in flight
        sta = 1'b1; ref_in = P50; triangle_in = P25; gate_ena = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sta = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("flush_done%0d", i), {31'd0, done_a}, 32'd0);
        end
        chk("flush_cmp", {31'd0, cmp_a}, 32'd0);
        gates_a("flush", 1'b0, 1'b0, 0);

        // sta in the same cycle as rst is ignored
        sta = 1'b1; rst = 1'b1;
        @(negedge clk);
        sta = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rststa_done%0d", i), {31'd0, done_a}, 32'd0);
        end

        // direct commutation instance: alternating cmp, counter wraps at 16
        for (int k = 1; k <= 17; k++) begin
            do_step(P50, P25, 1'b1);
            chk($sformatf("d0_hi%0d", k), {31'd0, hi_b}, 32'd1);
            chk($sformatf("d0_lohi%0d", k), {31'd0, lo_b}, 32'd0);
            chk($sformatf("d0_sw%0d", k), {28'd0, sw_b}, 32'(k % 16));
            if (k < 17) begin
                do_step(P25, P50, 1'b1);
                chk($sformatf("d0_lo%0d", k), {31'd0, lo_b}, 32'd1);
                chk($sformatf("d0_hilo%0d", k), {31'd0, hi_b}, 32'd0);
            end
        end
        chk("d0_wrap", {28'd0, sw_b}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
